fetch_branch_sequencer: RTL
===========================

// Module: fetch_branch_sequencer
// PURPOSE
// - Owns the 8-bit program counter and drives the fetch/execute sequence for the core.
// - Fetches one instruction per step from instruction memory over a req/ack handshake.
// - Presents condition-type instructions' 3-bit condition field to the combinational
//   condition evaluator, consumes its 1-bit result in the same cycle, then selects
//   PC+1 or the jump target (R0).
// PARAMETERS
// - WIDTH          8      PC, address, instruction and target width
// - RESET_PC       0      PC value after reset
// - BRANCH_OPCODE  2'b11  instr[WIDTH-1:WIDTH-2] value marking a condition (branch) instruction
// - MAX_WAIT       15     cycles FETCH waits for imem_ack before FAULT; range 1..255
// PORTS
// - clk           in   1      clock; all state updates on rising edge
// - rst_n         in   1      asynchronous, active-low reset
// - run_en        in   1      level; allows new fetches to start
// - imem_req      out  1      fetch request, held high in FETCH
// - imem_addr     out  WIDTH  fetch address = pc while imem_req high, else 0
// - imem_ack      in   1      memory accepts request; imem_data valid same cycle
// - imem_data     in   WIDTH  fetched instruction
// - instr         out  WIDTH  latched instruction (held until next fetch completes)
// - instr_valid   out  1      high for exactly the one EXEC cycle
// - cond_sel      out  3      instr[2:0] during EXEC of a branch, else 3'b000 (Never)
// - cond_result   in   1      evaluator output for cond_sel, combinational, same cycle
// - jump_target   in   WIDTH  R0 value, sampled in EXEC
// - branch_taken  out  1      high in EXEC when branch and cond_result=1
// - pc            out  WIDTH  current program counter
// - retired       out  16     instructions executed, wraps 16'hFFFF->0
// - fault         out  1      sticky fetch-timeout flag
// BEHAVIOUR
// - Reset, asynchronous, any state: state=IDLE, pc=RESET_PC, instr=0, retired=0,
//   wait_cnt=0, fault=0. All outputs low/zero at once: imem_req, imem_addr,
//   instr_valid, cond_sel, branch_taken.
// - States: IDLE, FETCH, EXEC, FAULT.
//   - IDLE: run_en=1 -> FETCH next cycle; otherwise stay.
//   - FETCH: imem_req=1, imem_addr=pc.
//     - imem_ack=1: instr<=imem_data, wait_cnt<=0 -> EXEC.
//       An ack in the first FETCH cycle is legal; min fetch latency 1 cycle.
//     - no ack: wait_cnt++. No ack with wait_cnt==MAX_WAIT-1 -> FAULT, fault<=1.
//       (MAX_WAIT FETCH cycles without ack.)
//     - ack and timeout in the same cycle: ack wins.
//   - EXEC, exactly 1 cycle: instr_valid=1.
//     - is_branch = (instr[WIDTH-1:WIDTH-2]==BRANCH_OPCODE).
//     - cond_sel = is_branch ? instr[2:0] : 0.
//     - branch_taken = is_branch & cond_result.
//     - pc <= branch_taken ? jump_target : pc+1.
//     - retired <= retired+1.
//     - Next state: FETCH if run_en, else IDLE.
//   - FAULT: imem_req=0; absorbing; exits only via rst_n.
// - run_en low during FETCH/EXEC does not abort: the current instruction completes,
//   then the block goes to IDLE.
// - pc+1 is modulo 2^WIDTH (8'hFF -> 8'h00). Jump to own address is legal and loops.
// - Cadence: an instruction takes (fetch cycles + 1) cycles. Back-to-back with
//   immediate ack = 1 instruction per 2 cycles.
// - imem_ack outside FETCH is ignored.
// TESTING
// 1. Reset, run_en=1, immediate ack, data 8'h01 x3
//    -> pc 0,1,2,3; instr_valid every 2nd cycle; retired=3; branch_taken=0.
// 2. instr=8'hC4 (Always), jump_target=8'h40 -> cond_sel=3'b100, branch_taken=1, next pc=8'h40.
//    instr=8'hC0 (Never) -> branch_taken=0, pc+1.
// 3. pc=8'hFF, non-branch instr -> pc=8'h00 next; retired increments.
// 4. Ack withheld 15 cycles -> fault=1 and FAULT on cycle 15, imem_req low.
//    Ack on cycle 15 instead -> EXEC, no fault.
// 5. Deassert rst_n mid-FETCH (imem_req=1, pc=8'h23)
//    -> imem_req=0, pc=RESET_PC, retired=0 immediately, before any clock edge.
// 6. run_en dropped in EXEC -> instruction retires, pc updates, state IDLE;
//    no imem_req until run_en=1.

Source files
------------

// File: rtl/fetch_branch_sequencer.sv
// Fetch/execute sequencer: owns the PC, fetches over req/ack,
// resolves conditional branches against the external evaluator.
module fetch_branch_sequencer #(
    parameter int               WIDTH         = 8,
    parameter logic [WIDTH-1:0] RESET_PC      = '0,
    parameter logic [1:0]       BRANCH_OPCODE = 2'b11,
    parameter int               MAX_WAIT      = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run_en,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_data,
    output logic [WIDTH-1:0] instr,
    output logic             instr_valid,
    output logic [2:0]       cond_sel,
    input  logic             cond_result,
    input  logic [WIDTH-1:0] jump_target,
    output logic             branch_taken,
    output logic [WIDTH-1:0] pc,
    output logic [15:0]      retired,
    output logic             fault
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_FAULT
    } state_t;

    localparam logic [7:0] LP_LAST = 8'(MAX_WAIT - 1);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_instr;
    logic [15:0]      r_retired;
    logic [7:0]       r_wait;
    logic             r_fault;
    logic             w_is_branch;
    logic             w_timeout;

    assign w_is_branch = (r_instr[WIDTH-1 -: 2] == BRANCH_OPCODE);

    assign instr   = r_instr;
    assign pc      = r_pc;
    assign retired = r_retired;
    assign fault   = r_fault;

    always_comb begin
        w_next       = r_state;
        imem_req     = 1'b0;
        imem_addr    = '0;
        instr_valid  = 1'b0;
        cond_sel     = 3'b000;
        branch_taken = 1'b0;
        w_timeout    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (run_en) w_next = S_FETCH;
            end
            S_FETCH: begin
                imem_req  = 1'b1;
                imem_addr = r_pc;
                // A late ack still beats the timeout
                if (imem_ack) begin
                    w_next = S_EXEC;
                end else if (r_wait == LP_LAST) begin
                    w_timeout = 1'b1;
                    w_next    = S_FAULT;
                end
            end
            S_EXEC: begin
                instr_valid  = 1'b1;
                if (w_is_branch) cond_sel = r_instr[2:0];
                branch_taken = w_is_branch & cond_result;
                w_next       = run_en ? S_FETCH : S_IDLE;
            end
            S_FAULT: begin
                w_next = S_FAULT;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_pc      <= RESET_PC;
            r_instr   <= '0;
            r_retired <= '0;
            r_wait    <= '0;
            r_fault   <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_FETCH: begin
                    if (imem_ack) begin
                        r_instr <= imem_data;
                        r_wait  <= '0;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                        if (w_timeout) r_fault <= 1'b1;
                    end
                end
                S_EXEC: begin
                    r_pc      <= branch_taken ? jump_target
                                              : r_pc + WIDTH'(1);
                    r_retired <= r_retired + 16'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
